// File: rtl/ds1302_burst_io.sv
// ds1302_burst_io
// Three-wire serial master for the DS1302 RTC. Accepts one command (single
// register or burst, clock/calendar or RAM space, read or write), frames it
// with CE, shifts the command byte and data bytes LSB first on SCLK, and
// reports completion with a done strobe (plus err for rejected lengths).
//
// Parameters
//   CLK_DIV    system clocks per SCLK half-period (2..65535)
//   CE_SETUP   clocks CE is held before first SCLK rise / after last fall (1..65536)
//   MAX_BYTES  maximum data bytes per command (1..31)
//
// Ports
//   clk, rst                   system clock, asynchronous active-high reset
//   cmd_valid/cmd_ready        command handshake (ready only in IDLE)
//   cmd_rd, cmd_ram            direction and address space of the command
//   cmd_addr, cmd_len          register address (single byte) and byte count
//   wr_data/wr_valid/wr_ready  write byte stream, one byte per handshake
//   rd_data/rd_valid           read byte stream, one-cycle strobe, no backpressure
//   done, err                  end-of-command strobe, err marks a rejected command
//   ds1302_*                   serial bus: CE, SCLK, IO output/enable/input
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// SETUP  | CE high, CE_SETUP clocks before the first SCLK edge
// CMD    | shifting the 8-bit command byte
// WDATA  | shifting write bytes, stalls at byte boundaries without wr_valid
// RDATA  | IO released, sampling read bytes on SCLK rises
// HOLD   | CE held CE_SETUP clocks after the last SCLK fall
// FIN    | CE low, done (and err when rejected) for one clock
module ds1302_burst_io #(
  parameter int CLK_DIV   = 50,
  parameter int CE_SETUP  = 256,
  parameter int MAX_BYTES = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rd,
  input  logic       cmd_ram,
  input  logic [4:0] cmd_addr,
  input  logic [4:0] cmd_len,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       done,
  output logic       err,
  output logic       ds1302_ce,
  output logic       ds1302_sclk,
  output logic       ds1302_io_o,
  output logic       ds1302_io_oe,
  input  logic       ds1302_io_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_CMD, S_WDATA, S_RDATA, S_HOLD, S_FIN
  } state_t;

  localparam logic [15:0] HALF_LD  = 16'(CLK_DIV - 1);
  localparam logic [15:0] SETUP_LD = 16'(CE_SETUP - 1);
  localparam logic [4:0]  MAX_LEN  = 5'(MAX_BYTES);

  state_t      r_state, w_state_n;
  logic [15:0] r_cnt, w_cnt_n;
  logic [2:0]  r_bit, w_bit_n;
  logic [4:0]  r_bytes, w_bytes_n;
  logic [7:0]  r_tx, w_tx_n;
  logic [7:0]  r_rx, w_rx_n;
  logic [7:0]  r_rd_data, w_rd_data_n;
  logic        r_rd_valid, w_rd_valid_n;
  logic        r_sclk, w_sclk_n;
  logic        r_oe, w_oe_n;
  logic        r_ce, w_ce_n;
  logic        r_rd, w_rd_n;
  logic        r_have, w_have_n;
  logic        r_err, w_err_n;
  logic        r_live;
  logic        w_cmd_ready, w_wr_ready, w_step, w_len_bad;
  logic [7:0]  w_cmd_byte, w_rx_shift;

  assign w_cmd_ready = (r_state == S_IDLE) && r_live;
  assign w_len_bad   = (cmd_len == 5'd0) || (cmd_len > MAX_LEN);
  assign w_cmd_byte  = {1'b1, cmd_ram, (cmd_len > 5'd1) ? 5'h1F : cmd_addr, cmd_rd};

  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_bit_n      = r_bit;
    w_bytes_n    = r_bytes;
    w_tx_n       = r_tx;
    w_rx_n       = r_rx;
    w_rd_data_n  = r_rd_data;
    w_rd_valid_n = 1'b0;
    w_sclk_n     = r_sclk;
    w_oe_n       = r_oe;
    w_ce_n       = r_ce;
    w_rd_n       = r_rd;
    w_have_n     = r_have;
    w_err_n      = r_err;
    w_wr_ready   = 1'b0;
    w_step       = 1'b0;
    w_rx_shift   = {ds1302_io_i, r_rx[7:1]};
    case (r_state)
      S_IDLE: begin
        if (cmd_valid && w_cmd_ready) begin
          w_rd_n = cmd_rd;
          if (w_len_bad) begin
            w_err_n   = 1'b1;
            w_state_n = S_FIN;
          end else begin
            w_err_n   = 1'b0;
            w_state_n = S_SETUP;
            w_tx_n    = w_cmd_byte;
            w_bytes_n = cmd_len;
            w_cnt_n   = SETUP_LD;
            w_ce_n    = 1'b1;
            w_oe_n    = 1'b1;
          end
        end
      end
      S_SETUP: begin
        if (r_cnt == 16'd0) begin
          w_state_n = S_CMD;
          w_cnt_n   = HALF_LD;
          w_bit_n   = 3'd0;
        end else begin
          w_cnt_n = r_cnt - 16'd1;
        end
      end
      S_CMD, S_WDATA, S_RDATA: begin
        // A write byte boundary freezes the bit timer (sclk low) until a
        // byte is handed over, so a byte is never shifted partially.
        if (r_state == S_WDATA && !r_have) begin
          w_wr_ready = wr_valid;
          if (wr_valid) begin
            w_tx_n   = wr_data;
            w_have_n = 1'b1;
            w_step   = 1'b1;
          end
        end else begin
          w_step = 1'b1;
        end
        if (w_step) begin
          if (r_cnt != 16'd0) begin
            w_cnt_n = r_cnt - 16'd1;
          end else if (!r_sclk) begin
            w_sclk_n = 1'b1;
            w_cnt_n  = HALF_LD;
            if (r_state == S_RDATA) begin
              w_rx_n = w_rx_shift;
              if (r_bit == 3'd7) begin
                w_rd_data_n  = w_rx_shift;
                w_rd_valid_n = 1'b1;
              end
            end
          end else begin
            w_sclk_n = 1'b0;
            w_cnt_n  = HALF_LD;
            w_tx_n   = {1'b0, r_tx[7:1]};
            w_bit_n  = r_bit + 3'd1;
            if (r_bit == 3'd7) begin
              w_have_n = 1'b0;
              if (r_state == S_CMD) begin
                w_state_n = r_rd ? S_RDATA : S_WDATA;
                if (r_rd) w_oe_n = 1'b0;
              end else begin
                w_bytes_n = r_bytes - 5'd1;
                if (r_bytes == 5'd1) begin
                  w_state_n = S_HOLD;
                  w_cnt_n   = SETUP_LD;
                  w_oe_n    = 1'b0;
                end
              end
            end
          end
        end
      end
      S_HOLD: begin
        if (r_cnt == 16'd0) begin
          w_state_n = S_FIN;
          w_ce_n    = 1'b0;
          w_oe_n    = 1'b0;
        end else begin
          w_cnt_n = r_cnt - 16'd1;
        end
      end
      S_FIN: begin
        w_state_n = S_IDLE;
        w_err_n   = 1'b0;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_bytes    <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_sclk     <= 1'b0;
      r_oe       <= 1'b0;
      r_ce       <= 1'b0;
      r_rd       <= 1'b0;
      r_have     <= 1'b0;
      r_err      <= 1'b0;
      r_live     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_bit      <= w_bit_n;
      r_bytes    <= w_bytes_n;
      r_tx       <= w_tx_n;
      r_rx       <= w_rx_n;
      r_rd_data  <= w_rd_data_n;
      r_rd_valid <= w_rd_valid_n;
      r_sclk     <= w_sclk_n;
      r_oe       <= w_oe_n;
      r_ce       <= w_ce_n;
      r_rd       <= w_rd_n;
      r_have     <= w_have_n;
      r_err      <= w_err_n;
      r_live     <= 1'b1;
    end
  end

  // The transmit register shifts in zeros, so io_o settles low once the
  // last bit has gone out and stays low through RDATA and IDLE.
  assign cmd_ready    = w_cmd_ready;
  assign wr_ready     = w_wr_ready;
  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;
  assign done         = (r_state == S_FIN);
  assign err          = (r_state == S_FIN) && r_err;
  assign ds1302_ce    = r_ce;
  assign ds1302_sclk  = r_sclk;
  assign ds1302_io_o  = r_tx[0];
  assign ds1302_io_oe = r_oe;

endmodule

// File: tb/tb_ds1302_burst_io.sv
// Directed bench for ds1302_burst_io: a table of commands with hand-computed
// command bytes, latencies and pulse counts, plus hand-written sequences for
// the write stall and the mid-burst reset. A small DS1302 model drives
// io_i from a byte table indexed by the SCLK rise count.
module tb_ds1302_burst_io;
  localparam int CD = 2;
  localparam int CS = 4;
  localparam int MB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0, cmd_rd = 1'b0, cmd_ram = 1'b0;
  logic [4:0] cmd_addr = '0, cmd_len = '0;
  logic [7:0] wr_data = '0;
  logic       wr_valid = 1'b0;
  logic       cmd_ready, wr_ready, rd_valid, done, err;
  logic [7:0] rd_data;
  logic       ds1302_ce, ds1302_sclk, ds1302_io_o, ds1302_io_oe, ds1302_io_i;

  always #5 clk = ~clk;

  ds1302_burst_io #(.CLK_DIV(CD), .CE_SETUP(CS), .MAX_BYTES(MB)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
    .cmd_ram(cmd_ram), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .ds1302_ce(ds1302_ce), .ds1302_sclk(ds1302_sclk), .ds1302_io_o(ds1302_io_o),
    .ds1302_io_oe(ds1302_io_oe), .ds1302_io_i(ds1302_io_i)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // bus monitors and device model
  int   rise_cnt = 0, tot_rises = 0, oe_fall = -1;
  int   done_n = 0, err_n = 0, ce_n = 0, wrr_n = 0, rd_n = 0;
  logic cap [0:511];
  logic [7:0] rdq [0:1023];
  logic [7:0] mdl [0:7];
  int   kk;

  always @(posedge ds1302_sclk or negedge ds1302_ce) begin
    if (!ds1302_ce) rise_cnt = 0;
    else begin
      if (rise_cnt < 512) cap[rise_cnt] = ds1302_io_o;
      rise_cnt++;
    end
  end

  always @(posedge ds1302_sclk) tot_rises++;

  always @(negedge ds1302_io_oe) if (ds1302_ce) oe_fall = rise_cnt;

  always_comb begin
    kk = rise_cnt - 8;
    ds1302_io_i = 1'b0;
    if (rise_cnt >= 8 && rise_cnt < 72) ds1302_io_i = mdl[kk[5:3]][kk[2:0]];
  end

  always @(negedge clk) begin
    if (done) done_n++;
    if (err) err_n++;
    if (ds1302_ce) ce_n++;
    if (wr_ready) wrr_n++;
    if (rd_valid) begin
      rdq[rd_n[9:0]] = rd_data;
      rd_n++;
    end
  end

  typedef struct {
    logic        rd;
    logic        ram;
    logic [4:0]  addr;
    logic [4:0]  len;
    logic [63:0] data;      // write bytes or model read bytes, byte 0 in [7:0]
    int          stall_at;  // write byte index withheld 20 clocks, -1 none
    logic [7:0]  exp_cmd;
    logic        exp_err;
    int          exp_lat;   // cycles, accept cycle = 1, through the done cycle
    int          exp_rises;
  } vec_t;

  vec_t tbl [0:6];

  task automatic feed(input vec_t t, input int i);
    int n, bad;
    for (int j = 0; j < int'(t.len); j++) begin
      if (j == t.stall_at) begin
        wr_valid = 1'b0;
        n = 0;
        while (!(rise_cnt == 8 * (j + 1) && !ds1302_sclk) && n < 4000) begin
          @(negedge clk);
          n++;
        end
        bad = 0;
        for (int s = 0; s < 20; s++) begin
          @(negedge clk);
          if (ds1302_sclk || !ds1302_ce || wr_ready || rise_cnt != 8 * (j + 1)) bad++;
        end
        check($sformatf("t%0d_stall_hold", i), bad, 0);
      end
      wr_data  = t.data[8*j +: 8];
      wr_valid = 1'b1;
      #1;
      n = 0;
      while (!wr_ready && n < 4000) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("t%0d_wr_hs%0d", i, j), wr_ready, 1);
      @(posedge clk);
      #1 wr_valid = 1'b0;
    end
  endtask

  task automatic issue(input vec_t t);
    int n;
    for (int j = 0; j < 8; j++) mdl[j] = t.data[8*j +: 8];
    @(negedge clk);
    cmd_rd = t.rd; cmd_ram = t.ram; cmd_addr = t.addr; cmd_len = t.len;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic run_txn(input int i);
    vec_t t;
    int lat, b_done, b_err, b_ce, b_wrr, b_rd, b_rises;
    logic [7:0] got;
    t = tbl[i];
    b_done = done_n; b_err = err_n; b_ce = ce_n; b_wrr = wrr_n;
    b_rd = rd_n; b_rises = tot_rises;
    issue(t);
    lat = 1;
    fork
      begin
        if (!t.rd && !t.exp_err) feed(t, i);
      end
      begin
        do begin
          @(negedge clk);
          lat++;
        end while (!done && lat < 6000);
      end
    join
    repeat (3) @(negedge clk);
    check($sformatf("t%0d_latency", i), lat, t.exp_lat);
    check($sformatf("t%0d_done_cnt", i), done_n - b_done, 1);
    check($sformatf("t%0d_err_cnt", i), err_n - b_err, {31'd0, t.exp_err});
    check($sformatf("t%0d_ce_cycles", i), ce_n - b_ce, t.exp_lat - 2);
    check($sformatf("t%0d_sclk_pulses", i), tot_rises - b_rises, t.exp_rises);
    if (!t.exp_err) begin
      for (int b = 0; b < 8; b++) got[b] = cap[b];
      check($sformatf("t%0d_cmd_byte", i), got, t.exp_cmd);
      check($sformatf("t%0d_oe_fall_pulse", i), oe_fall, t.rd ? 8 : 8 * (int'(t.len) + 1));
      if (t.rd) begin
        check($sformatf("t%0d_rd_cnt", i), rd_n - b_rd, int'(t.len));
        check($sformatf("t%0d_wr_ready_cnt", i), wrr_n - b_wrr, 0);
        for (int j = 0; j < int'(t.len); j++)
          check($sformatf("t%0d_rd_byte%0d", i, j), rdq[b_rd + j], t.data[8*j +: 8]);
      end else begin
        check($sformatf("t%0d_wr_ready_cnt", i), wrr_n - b_wrr, int'(t.len));
        for (int j = 0; j < int'(t.len); j++) begin
          for (int b = 0; b < 8; b++) got[b] = cap[8 * (j + 1) + b];
          check($sformatf("t%0d_wr_byte%0d", i, j), got, t.data[8*j +: 8]);
        end
      end
    end
  endtask

  initial begin
    int n, b_done;
    tbl[0] = '{rd:1'b0, ram:1'b0, addr:5'd0, len:5'd1, data:64'h59, stall_at:-1,
               exp_cmd:8'h80, exp_err:1'b0, exp_lat:74, exp_rises:16};
    tbl[1] = '{rd:1'b1, ram:1'b0, addr:5'd2, len:5'd1, data:64'h23, stall_at:-1,
               exp_cmd:8'h85, exp_err:1'b0, exp_lat:74, exp_rises:16};
    tbl[2] = '{rd:1'b1, ram:1'b0, addr:5'd5, len:5'd8, data:64'h0706050403020100,
               stall_at:-1, exp_cmd:8'hBF, exp_err:1'b0, exp_lat:298, exp_rises:72};
    tbl[3] = '{rd:1'b0, ram:1'b1, addr:5'd0, len:5'd3, data:64'hC3B2A1, stall_at:1,
               exp_cmd:8'hFE, exp_err:1'b0, exp_lat:158, exp_rises:32};
    tbl[4] = '{rd:1'b0, ram:1'b0, addr:5'd1, len:5'd0, data:64'h0, stall_at:-1,
               exp_cmd:8'h00, exp_err:1'b1, exp_lat:2, exp_rises:0};
    tbl[5] = '{rd:1'b1, ram:1'b1, addr:5'd1, len:5'd9, data:64'h0, stall_at:-1,
               exp_cmd:8'h00, exp_err:1'b1, exp_lat:2, exp_rises:0};
    tbl[6] = '{rd:1'b0, ram:1'b1, addr:5'd3, len:5'd1, data:64'h3C, stall_at:-1,
               exp_cmd:8'hC6, exp_err:1'b0, exp_lat:74, exp_rises:16};

    #1 rst = 1'b1;
    #12;
    check("reset_outputs",
          {ds1302_ce, ds1302_sclk, ds1302_io_oe, ds1302_io_o, cmd_ready, wr_ready,
           rd_valid, done, err, rd_data}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check("ready_after_reset", cmd_ready, 1);

    for (int i = 0; i < 7; i++) run_txn(i);

    // reset in the middle of the 3rd byte of a burst read
    b_done = done_n;
    issue(tbl[2]);
    n = 0;
    while (rise_cnt < 26 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("midburst_rd_data", rd_data, 8'h01);
    cmd_valid = 1'b1; cmd_len = 5'd1;
    #1 check("busy_not_ready", cmd_ready, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check("async_reset_outputs",
             {ds1302_ce, ds1302_sclk, ds1302_io_oe, ds1302_io_o, cmd_ready, wr_ready,
              rd_valid, done, err, rd_data}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 check("ready_low_before_edge", cmd_ready, 0);
    @(posedge clk);
    #1 check("ready_after_rst_release", cmd_ready, 1);
    repeat (5) @(negedge clk);
    check("no_done_after_abort", done_n - b_done, 0);
    run_txn(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
